phase_interval_timer: RTL and testbench
=======================================

Name: phase_interval_timer

Overview:
- Upstream interval source for the traffic-light controller; drives its `t` input.
- Controller reports its current phase; this block loads that phase's duration and counts it down on tick enables.
- Emits a one-clock `t` pulse at expiry, then waits for the next phase.
- Supports bounded green extension on vehicle demand; runs on the divided 4 Hz system clock.

Parameters:
WIDTH, 6, counter and `remaining` width; every duration must be ≤ 2^WIDTH−1
GREEN_TICKS, 20, ticks in GREEN phase (≥1)
YELLOW_TICKS, 8, ticks in YELLOW phase (≥1)
CLEAR_TICKS, 4, ticks in ALL-RED clearance phase (≥1)
EXT_TICKS, 8, ticks added per green extension (≥1)
MAX_EXT, 2, maximum extensions granted per green phase

Ports:
clock  input  1  system clock (4 Hz divided clock)
reset  input  1  asynchronous, active-high reset
tick_en  input  1  count enable; the counter moves only on edges where this is 1
phase  input  2  current controller phase: 00 GREEN, 01 YELLOW, 10 ALL-RED, 11 HOLD
extend_req  input  1  vehicle-present request; sampled only as described below
t  output  1  registered one-clock expiry pulse to the traffic-light controller
remaining  output  WIDTH  current count while COUNTING, else 0
busy  output  1  1 while COUNTING
ext_used  output  2  number of extensions granted in the current green phase

Behaviour:
- State register values: COUNTING, EXPIRED, HOLD. Internal registers: `phase_q`, `count`, `ext_cnt`.
- Reset (asynchronous, any time, including mid-count):
  - `phase_q`=11, `count`=0, `ext_cnt`=0, `t`=0, state HOLD.
  - The first clock after reset release with `phase`≠11 triggers a reload.
- Priority per clock edge, highest first: reset > phase change > tick.
- Phase change (`phase`≠`phase_q`), regardless of `tick_en`:
  - `phase_q`←`phase`, `ext_cnt`←0, `t`←0.
  - If the new phase is 11: state HOLD, `count`←0.
  - Otherwise: `count`←duration−1 (GREEN/YELLOW/CLEAR_TICKS), state COUNTING.
  - A phase change during COUNTING aborts the old interval with no `t` pulse.
- COUNTING, `tick_en`=1, no phase change:
  - `count`>1, or `count`=1 without a granted extension: `count`←`count`−1.
  - `count`=1, `phase_q`=GREEN, `extend_req`=1, `ext_cnt`<MAX_EXT: extension granted; `count`←EXT_TICKS, `ext_cnt`←`ext_cnt`+1. This adds exactly EXT_TICKS ticks.
  - `count`=0: `t`←1, state EXPIRED.
- COUNTING, `tick_en`=0: all registers hold; `t`←0.
- Timing: with `tick_en` tied high, `t` rises D clocks after the load edge (D = phase duration) and is high for exactly one clock.
- EXPIRED: `t`←0 next edge; `count` holds 0; no further pulse until a phase change.
- HOLD: counter frozen; `t` is never asserted.
- Re-entering the same phase value does not count as a change. The controller must leave a phase for the interval to restart.
- `extend_req` is ignored outside GREEN, at any `count`≠1, and when `ext_cnt`=MAX_EXT.
- Outputs:
  - `busy` = (state==COUNTING).
  - `remaining` = `count` when COUNTING, else 0.
  - `ext_used` = `ext_cnt`, saturating at MAX_EXT.
- Arithmetic: unsigned, WIDTH bits. Decrement never occurs at 0. Extension loads a constant, so no overflow is possible.

Test Plan:
- Reset released, `phase`=00, `tick_en`=1, `extend_req`=0: `remaining`=19 after the load edge; `t` high for exactly one clock, 20 clocks after load; then `busy`=0, `remaining`=0.
- GREEN with `extend_req` held 1: extensions granted at `count`=1 twice; `ext_used`=2; `t` occurs 36 clocks after load. A third request is ignored.
- YELLOW with `extend_req`=1: no extension; `t` at 8 clocks; `ext_used`=0.
- `tick_en` toggling 1,0,1,0 in ALL-RED: `t` at 8 clocks (4 ticks); `remaining` holds on enable-low cycles.
- Phase change 00→01 at `count`=5: no `t`; `remaining`=7 next clock. Phase change coincident with the expiry edge: reload wins, `t` stays 0.
- Assert `reset` mid-GREEN at `count`=10: `t`=0, `remaining`=0, `busy`=0 immediately (asynchronous). After release, a full 20-clock green is produced. `phase`=11: `t` never asserts over 100 clocks.

Source files
------------

// File: rtl/phase_interval_timer.sv
// phase_interval_timer: loads the controller's current phase duration, counts it down on
// tick enables and pulses t for one clock at expiry, with bounded green extensions.
module phase_interval_timer #(
    parameter int WIDTH        = 6,
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 8,
    parameter int CLEAR_TICKS  = 4,
    parameter int EXT_TICKS    = 8,
    parameter int MAX_EXT      = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick_en,
    input  logic [1:0]       phase,
    input  logic             extend_req,
    output logic             t,
    output logic [WIDTH-1:0] remaining,
    output logic             busy,
    output logic [1:0]       ext_used
);
    typedef enum logic [1:0] {COUNTING, EXPIRED, HOLD} state_t;

    localparam logic [WIDTH-1:0] GREEN_LOAD  = WIDTH'(GREEN_TICKS - 1);
    localparam logic [WIDTH-1:0] YELLOW_LOAD = WIDTH'(YELLOW_TICKS - 1);
    localparam logic [WIDTH-1:0] CLEAR_LOAD  = WIDTH'(CLEAR_TICKS - 1);
    localparam logic [WIDTH-1:0] EXT_LOAD    = WIDTH'(EXT_TICKS);
    localparam logic [1:0]       EXT_MAX     = 2'(MAX_EXT);

    state_t           state, state_n;
    logic [1:0]       phase_q, ext_cnt, ext_n;
    logic [WIDTH-1:0] count, count_n, load;
    logic             t_n;

    assign load = phase == 2'd0 ? GREEN_LOAD : phase == 2'd1 ? YELLOW_LOAD : CLEAR_LOAD;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= HOLD;
            phase_q <= 2'd3;
            count   <= '0;
            ext_cnt <= '0;
            t       <= 1'b0;
        end else begin
            state   <= state_n;
            phase_q <= phase;
            count   <= count_n;
            ext_cnt <= ext_n;
            t       <= t_n;
        end
    end

    // A phase change outranks any tick; an extension replaces the final decrement.
    always_comb begin
        state_n = state;
        count_n = count;
        ext_n   = ext_cnt;
        t_n     = 1'b0;
        if (phase != phase_q) begin
            ext_n   = '0;
            state_n = phase == 2'd3 ? HOLD : COUNTING;
            count_n = phase == 2'd3 ? '0 : load;
        end else if (state == COUNTING && tick_en) begin
            if (count == '0) begin
                t_n     = 1'b1;
                state_n = EXPIRED;
            end else if (count == WIDTH'(1) && phase_q == 2'd0 && extend_req && ext_cnt < EXT_MAX) begin
                count_n = EXT_LOAD;
                ext_n   = ext_cnt + 2'd1;
            end else begin
                count_n = count - WIDTH'(1);
            end
        end
    end

    assign busy      = state == COUNTING;
    assign remaining = busy ? count : '0;
    assign ext_used  = ext_cnt > EXT_MAX ? EXT_MAX : ext_cnt;
endmodule

// File: tb/tb_phase_interval_timer.sv
// tb_phase_interval_timer: directed scenarios plus randomized traffic checked against a
// ticks-until-pulse reference model.
module tb_phase_interval_timer;
    logic       clock = 1'b0;
    logic       reset, tick_en, extend_req, t, busy;
    logic [1:0] phase, ext_used;
    logic [5:0] remaining;
    int checks = 0;
    int passes = 0;

    // reference model: ticks still needed before the pulse, not the hardware count
    int m_phase, m_left, m_ext;
    bit m_active, m_t;

    phase_interval_timer dut (
        .clock(clock), .reset(reset), .tick_en(tick_en), .phase(phase),
        .extend_req(extend_req), .t(t), .remaining(remaining), .busy(busy), .ext_used(ext_used)
    );

    always #5 clock = ~clock;

    function automatic int dur(input int p);
        return p == 0 ? 20 : p == 1 ? 8 : 4;
    endfunction

    task automatic model_reset();
        m_phase = 3; m_left = 0; m_ext = 0; m_active = 0; m_t = 0;
    endtask

    task automatic model_edge();
        m_t = 0;
        if (int'(phase) != m_phase) begin
            m_phase = int'(phase); m_ext = 0;
            m_active = m_phase != 3;
            m_left = m_active ? dur(m_phase) : 0;
        end else if (m_active && tick_en) begin
            if (m_left == 2 && m_phase == 0 && extend_req && m_ext < 2) begin
                m_left = m_left - 1 + 8;
                m_ext++;
            end else begin
                m_left--;
                if (m_left == 0) begin m_t = 1; m_active = 0; end
            end
        end
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic enter(input logic [1:0] p);
        phase = 2'd3; tick();
        phase = p; tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; phase = 2'd0; tick_en = 1'b1; extend_req = 1'b0;
        tick(); tick();
        checks++; if (t !== 1'b0) $display("FAIL reset_t: got %0b exp 0", t); else passes++;
        checks++; if (remaining !== 6'd0) $display("FAIL reset_remaining: got %0d exp 0", remaining); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b exp 0", busy); else passes++;
        checks++; if (ext_used !== 2'd0) $display("FAIL reset_ext_used: got %0d exp 0", ext_used); else passes++;
        reset = 1'b0;
    endtask

    task automatic test_green_basic();
        int first = -1, n = 0;
        tick();
        checks++; if (remaining !== 6'd19) $display("FAIL green_load: got %0d exp 19", remaining); else passes++;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (t) begin n++; if (first < 0) first = k; end
        end
        checks++; if (first != 20) $display("FAIL green_t_time: got %0d exp 20", first); else passes++;
        checks++; if (n != 1) $display("FAIL green_t_width: got %0d exp 1", n); else passes++;
        checks++; if (busy !== 1'b0 || remaining !== 6'd0) $display("FAIL green_after: got busy %0b rem %0d exp 0 0", busy, remaining); else passes++;
    endtask

    task automatic test_extension();
        int first = -1, n = 0;
        extend_req = 1'b1;
        enter(2'd0);
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (t) begin n++; if (first < 0) first = k; end
        end
        checks++; if (first != 36) $display("FAIL ext_t_time: got %0d exp 36", first); else passes++;
        checks++; if (n != 1) $display("FAIL ext_t_width: got %0d exp 1", n); else passes++;
        checks++; if (ext_used !== 2'd2) $display("FAIL ext_used: got %0d exp 2", ext_used); else passes++;
    endtask

    task automatic test_yellow_no_ext();
        int first = -1;
        extend_req = 1'b1;
        enter(2'd1);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (t && first < 0) first = k;
        end
        checks++; if (first != 8) $display("FAIL yellow_t_time: got %0d exp 8", first); else passes++;
        checks++; if (ext_used !== 2'd0) $display("FAIL yellow_ext_used: got %0d exp 0", ext_used); else passes++;
        extend_req = 1'b0;
    endtask

    task automatic test_tick_toggle();
        int first = -1;
        tick_en = 1'b1;
        enter(2'd2);
        for (int k = 1; k <= 12; k++) begin
            tick_en = k[0] ? 1'b0 : 1'b1;
            tick();
            if (k == 1) begin
                checks++; if (remaining !== 6'd3) $display("FAIL toggle_hold1: got %0d exp 3", remaining); else passes++;
            end
            if (k == 3) begin
                checks++; if (remaining !== 6'd2) $display("FAIL toggle_hold3: got %0d exp 2", remaining); else passes++;
            end
            if (t && first < 0) first = k;
        end
        checks++; if (first != 8) $display("FAIL toggle_t_time: got %0d exp 8", first); else passes++;
        tick_en = 1'b1;
    endtask

    task automatic test_phase_change();
        enter(2'd0);
        for (int k = 1; k <= 14; k++) tick();
        checks++; if (remaining !== 6'd5) $display("FAIL pc_pre: got %0d exp 5", remaining); else passes++;
        phase = 2'd1; tick();
        checks++; if (remaining !== 6'd7 || t !== 1'b0) $display("FAIL pc_reload: got rem %0d t %0b exp 7 0", remaining, t); else passes++;
        for (int k = 1; k <= 7; k++) tick();
        checks++; if (remaining !== 6'd0 || busy !== 1'b1) $display("FAIL pc_at_zero: got rem %0d busy %0b exp 0 1", remaining, busy); else passes++;
        phase = 2'd2; tick();
        checks++; if (t !== 1'b0 || remaining !== 6'd3 || busy !== 1'b1) $display("FAIL pc_expiry_edge: got t %0b rem %0d busy %0b exp 0 3 1", t, remaining, busy); else passes++;
    endtask

    task automatic test_async_reset();
        int first = -1, n = 0;
        enter(2'd0);
        for (int k = 1; k <= 9; k++) tick();
        checks++; if (remaining !== 6'd10) $display("FAIL ar_pre: got %0d exp 10", remaining); else passes++;
        #2 reset = 1'b1; #1;
        checks++; if (t !== 1'b0 || remaining !== 6'd0 || busy !== 1'b0) $display("FAIL ar_async: got t %0b rem %0d busy %0b exp 0 0 0", t, remaining, busy); else passes++;
        tick(); reset = 1'b0;
        tick();
        checks++; if (remaining !== 6'd19) $display("FAIL ar_reload: got %0d exp 19", remaining); else passes++;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (t) begin n++; if (first < 0) first = k; end
        end
        checks++; if (first != 20 || n != 1) $display("FAIL ar_full_green: got at %0d x%0d exp at 20 x1", first, n); else passes++;
        phase = 2'd3; n = 0;
        for (int k = 1; k <= 100; k++) begin tick(); if (t) n++; end
        checks++; if (n != 0 || busy !== 1'b0) $display("FAIL hold_no_t: got %0d pulses busy %0b exp 0 0", n, busy); else passes++;
    endtask

    task automatic test_random();
        int bad = 0;
        @(negedge clock); reset = 1'b1; phase = 2'd3; model_reset();
        @(negedge clock); reset = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 15) == 0) phase = 2'($urandom_range(0, 3));
            tick_en = $urandom_range(0, 3) != 0;
            extend_req = $urandom_range(0, 1) == 1;
            @(posedge clock); model_edge(); #1;
            checks++;
            if (t !== m_t || busy !== m_active || ext_used !== 2'(m_ext) ||
                remaining !== (m_active ? 6'(m_left - 1) : 6'd0)) begin
                bad++;
                if (bad <= 10) $display("FAIL rand cyc %0d: got t%0b b%0b e%0d r%0d exp t%0b b%0b e%0d r%0d",
                    k, t, busy, ext_used, remaining, m_t, m_active, m_ext, m_active ? m_left - 1 : 0);
            end else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_green_basic();
        test_extension();
        test_yellow_no_ext();
        test_tick_toggle();
        test_phase_change();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
